pwm_width_sequencer: RTL and testbench
======================================

Name: pwm_width_sequencer

Overview:
- Upstream feeder for the photonic-switch PWM stage.
- Holds a small table of pulse-width words W, loaded by the controller.
- Steps through the table one entry per PWM period, presenting the next W on the core clock whenever the PWM stage signals end-of-period.
- Supports one-shot and looping sequences and a graceful stop at a period boundary.

Parameters:
- W_WIDTH, 13, width of the pulse-width word W (matches the PWM stage input).
- DEPTH, 8, number of table entries.
- ADDR_W, 3, index width; must satisfy 2**ADDR_W >= DEPTH.
- W_MAX, 8191, largest legal W; writes above it are clamped to it.

Ports:
- clk  in  1  core clock (200 MHz).
- reset  in  1  asynchronous, active-low; 0 = reset.
- en  in  1  global enable; 0 freezes all state.
- wr_en  in  1  table write strobe.
- wr_addr  in  ADDR_W  table write address.
- wr_data  in  W_WIDTH  table write data.
- seq_len  in  ADDR_W+1  number of entries to play, 1..DEPTH; latched on start.
- loop  in  1  1 = wrap to entry 0 after the last entry; latched on start.
- start  in  1  single-cycle request to begin the sequence.
- stop  in  1  single-cycle request to end the sequence at the next period boundary.
- period_end  in  1  single-cycle pulse from the PWM stage at the end of each period.
- W  out  W_WIDTH  current pulse width to the PWM stage.
- W_valid  out  1  W is live; the PWM stage runs only while this is 1.
- idx  out  ADDR_W  index of the table entry currently presented.
- busy  out  1  1 in RUN.
- done  out  1  single-cycle pulse when the sequence ends.
- wr_rej  out  1  single-cycle pulse when a write is refused.

Behaviour:
- Reset (reset=0, async): state IDLE; W=0, W_valid=0, idx=0, busy=0, done=0, wr_rej=0; all table entries and latched seq_len/loop cleared to 0; stop_pending=0.
- en=0: no state, table, output or pulse changes; start, stop, period_end and wr_en are ignored (not queued). done and wr_rej are forced to 0.
- States: IDLE, RUN.

IDLE:
- wr_en writes table[wr_addr] <= min(wr_data, W_MAX) on the next edge.
- wr_addr >= DEPTH: write dropped and wr_rej pulses.
- start with 1 <= seq_len <= DEPTH: the next edge latches seq_len and loop, sets W=table[0], idx=0, W_valid=1, busy=1, and enters RUN.
- start with seq_len=0 or seq_len>DEPTH: ignored; stays IDLE with no pulse.
- start and wr_en in the same cycle: the write takes effect and the sequence starts. table[0] is read pre-write, so W is the old value.

RUN:
- wr_en is refused: table unchanged, wr_rej pulses one cycle later.
- start is ignored.
- stop sets stop_pending.
- On period_end (one-cycle latency: new outputs on the edge after the pulse):
  - stop_pending, or stop asserted in the same cycle: go to IDLE (W=0, W_valid=0, busy=0, idx=0, done pulse, stop_pending cleared).
  - else if idx < seq_len-1: idx+1 and W=table[idx+1].
  - else if loop=1: idx=0 and W=table[0].
  - else: go to IDLE exactly as in the stop case.
- period_end in IDLE is ignored.
- W changes only on these edges, so it is stable for a whole PWM period.
- Reset asserted mid-RUN: immediate return to reset values; the stored table is lost.

Decomposition:
- Shared package pwm_pkg holds:
  - W_WIDTH and W_MAX constants, shared with the PWM stage;
  - the state enum (IDLE, RUN).
- One natural sub-module, width_table: a DEPTH x W_WIDTH register file with clamped synchronous write, asynchronous read and async active-low clear. The sequencer FSM lives in the top-level module.

Test Plan:
- Reset/write: write 6479 to addr 0 and 9000 to addr 1 -> table[0]=6479, table[1]=8191 (clamped); wr_addr=9 with DEPTH=8 -> wr_rej pulse, table unchanged.
- One-shot sequence:
  - setup: table={100,200,300}, seq_len=3, loop=0, start, then three period_end pulses;
  - W sequence 100 -> 200 -> 300, each change one cycle after its pulse;
  - after the third pulse: W=0, W_valid=0, done pulse.
- Loop: same table with loop=1 and five period_end pulses -> W sequence 100,200,300,100,200,300; busy stays 1.
- Stop:
  - stop mid-period -> W holds until the next period_end, then W_valid=0 and done;
  - stop coincident with period_end -> ends on that same boundary.
- Guards and freeze:
  - start with seq_len=0 -> stays IDLE;
  - wr_en during RUN -> wr_rej, table unchanged;
  - en=0 during period_end -> no advance of idx or W.
- Async reset mid-RUN at idx=2 -> outputs 0 immediately without a clock edge; table reads 0 afterwards.

Source files
------------

// File: rtl/pwm_pkg.sv
// Constants and state type shared between the width sequencer and the PWM stage.
package pwm_pkg;

  localparam int W_WIDTH = 13;
  localparam int W_MAX   = 8191;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/pwm_width_sequencer_width_table.sv
// Pulse-width table: clamped synchronous write, asynchronous read, async active-low clear.
module width_table #(
  parameter int W_WIDTH = pwm_pkg::W_WIDTH,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 3,
  parameter int W_MAX   = pwm_pkg::W_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [W_WIDTH-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [W_WIDTH-1:0] rdata_o
);

  localparam logic [W_WIDTH-1:0] W_MAX_L = W_WIDTH'(W_MAX);

  logic [W_WIDTH-1:0] mem_q [DEPTH];
  logic [W_WIDTH-1:0] wclamp;

  assign wclamp = (wdata_i > W_MAX_L) ? W_MAX_L : wdata_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (waddr_i == ADDR_W'(i)) mem_q[i] <= wclamp;
      end
    end
  end

  // Decoded read keeps the index width independent of DEPTH.
  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr_i == ADDR_W'(i)) rdata_o = mem_q[i];
    end
  end

endmodule

// File: rtl/pwm_width_sequencer.sv
// Steps through the width table one entry per PWM period, one-shot or looping.
// state | meaning
// IDLE  | table writable, W parked at 0, waiting for start
// RUN   | presenting table[idx]; advances on period_end, ends on stop or last entry
module pwm_width_sequencer #(
  parameter int W_WIDTH = pwm_pkg::W_WIDTH,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 3,
  parameter int W_MAX   = pwm_pkg::W_MAX
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [W_WIDTH-1:0] wr_data,
  input  logic [ADDR_W:0]    seq_len,
  input  logic               loop,
  input  logic               start,
  input  logic               stop,
  input  logic               period_end,
  output logic [W_WIDTH-1:0] W,
  output logic               W_valid,
  output logic [ADDR_W-1:0]  idx,
  output logic               busy,
  output logic               done,
  output logic               wr_rej
);
  import pwm_pkg::*;

  localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_e              state_q, state_d;
  logic [W_WIDTH-1:0]  w_q, w_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic                loop_q, loop_d;
  logic                pend_q, pend_d;
  logic                done_q, done_d;
  logic                rej_q, rej_d;

  logic                tbl_we;
  logic [ADDR_W-1:0]   rd_addr;
  logic [W_WIDTH-1:0]  rd_data;
  logic [ADDR_W-1:0]   idx_nxt;
  logic                last, addr_ok, len_ok;

  width_table #(
    .W_WIDTH(W_WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .W_MAX(W_MAX)
  ) u_table (
    .clk    (clk),
    .rst_n  (reset),
    .we_i   (tbl_we),
    .waddr_i(wr_addr),
    .wdata_i(wr_data),
    .raddr_i(rd_addr),
    .rdata_o(rd_data)
  );

  assign idx_nxt = idx_q + ADDR_W'(1);
  assign last    = ({1'b0, idx_q} + LEN_ONE) >= len_q;
  assign addr_ok = {1'b0, wr_addr} < DEPTH_L;
  assign len_ok  = (seq_len >= LEN_ONE) && (seq_len <= DEPTH_L);
  // Read port pre-selects whatever entry the next boundary would present.
  assign rd_addr = (state_q == RUN && !last) ? idx_nxt : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      w_q     <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      len_q   <= '0;
      loop_q  <= 1'b0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      loop_q  <= loop_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      rej_q   <= rej_d;
    end
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    len_d   = len_q;
    loop_d  = loop_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    rej_d   = 1'b0;
    tbl_we  = 1'b0;
    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (wr_en) begin
            if (addr_ok) tbl_we = 1'b1;
            else         rej_d  = 1'b1;
          end
          if (start && len_ok) begin
            state_d = RUN;
            len_d   = seq_len;
            loop_d  = loop;
            w_d     = rd_data;
            valid_d = 1'b1;
            idx_d   = '0;
            pend_d  = 1'b0;
          end
        end
        RUN: begin
          rej_d = wr_en;
          if (stop) pend_d = 1'b1;
          if (period_end) begin
            if (pend_q || stop || (last && !loop_q)) begin
              state_d = IDLE;
              w_d     = '0;
              valid_d = 1'b0;
              idx_d   = '0;
              pend_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              idx_d = last ? '0 : idx_nxt;
              w_d   = rd_data;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    W       = w_q;
    W_valid = valid_q;
    idx     = idx_q;
    busy    = (state_q == RUN);
    done    = done_q & en;
    wr_rej  = rej_q & en;
  end

endmodule

// File: tb/tb_pwm_width_sequencer.sv
// Directed bench for pwm_width_sequencer with a playlist-level reference model.
module tb_pwm_width_sequencer;

  localparam int WW = 14;
  localparam int AW = 4;
  localparam int DP = 8;
  localparam int WMAX = 8191;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [WW-1:0] wr_data = '0;
  logic [AW:0]   seq_len = '0;
  logic          loop = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          period_end = 1'b0;
  logic [WW-1:0] W;
  logic          W_valid;
  logic [AW-1:0] idx;
  logic          busy, done, wr_rej;

  int checks = 0;
  int failures = 0;
  logic chk_on = 1'b0;

  pwm_width_sequencer #(.W_WIDTH(WW), .DEPTH(DP), .ADDR_W(AW), .W_MAX(WMAX)) dut (
    .clk(clk), .reset(reset), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .seq_len(seq_len), .loop(loop), .start(start),
    .stop(stop), .period_end(period_end), .W(W), .W_valid(W_valid),
    .idx(idx), .busy(busy), .done(done), .wr_rej(wr_rej)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a table, a playing flag, a position in the playlist.
  int  m_tab [DP];
  bit  m_run, m_lp, m_pend, m_done, m_rej;
  int  m_pos, m_n, m_w;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_run <= 0; m_lp <= 0; m_pend <= 0; m_done <= 0; m_rej <= 0;
      m_pos <= 0; m_n <= 0; m_w <= 0;
      for (int i = 0; i < DP; i++) m_tab[i] <= 0;
    end else begin
      m_done <= 0;
      m_rej  <= 0;
      if (en) begin
        if (!m_run) begin
          if (wr_en) begin
            if (int'(wr_addr) < DP) m_tab[int'(wr_addr)] <= (int'(wr_data) > WMAX) ? WMAX : int'(wr_data);
            else m_rej <= 1;
          end
          if (start && seq_len >= 1 && int'(seq_len) <= DP) begin
            m_run <= 1; m_pos <= 0; m_n <= int'(seq_len); m_lp <= loop;
            m_pend <= 0; m_w <= m_tab[0];
          end
        end else begin
          m_rej <= wr_en;
          if (period_end) begin
            if (m_pend || stop || (m_pos + 1 >= m_n && !m_lp)) begin
              m_run <= 0; m_pos <= 0; m_w <= 0; m_pend <= 0; m_done <= 1;
            end else if (m_pos + 1 < m_n) begin
              m_pos <= m_pos + 1; m_w <= m_tab[m_pos + 1];
            end else begin
              m_pos <= 0; m_w <= m_tab[0];
            end
          end else if (stop) begin
            m_pend <= 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset && chk_on) begin
      cmp("W", int'(W), m_w);
      cmp("W_valid", int'(W_valid), int'(m_run));
      cmp("idx", int'(idx), m_pos);
      cmp("busy", int'(busy), int'(m_run));
      cmp("done", int'(done), int'(m_done & en));
      cmp("wr_rej", int'(wr_rej), int'(m_rej & en));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = WW'(d);
    step();
    wr_en = 1'b0;
  endtask

  task automatic go(input int n, input bit lp);
    seq_len = (AW+1)'(n); loop = lp; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pe();
    period_end = 1'b1;
    step();
    period_end = 1'b0;
  endtask

  initial begin
    int exp_loop [5] = '{200, 300, 100, 200, 300};
    #1;
    cmp("rst_W", int'(W), 0);
    cmp("rst_valid_busy", int'({W_valid, busy, done, wr_rej}), 0);
    #11 reset = 1'b1;
    chk_on = 1'b1;
    step();

    // writes, clamp, out-of-range reject
    wr(0, 6479);
    wr(1, 9000);
    wr(9, 77);
    cmp("rej_addr9", int'(wr_rej), 1);
    step();
    cmp("rej_single", int'(wr_rej), 0);
    go(2, 1'b0);
    cmp("tab0", int'(W), 6479);
    pe();
    cmp("tab1_clamp", int'(W), 8191);
    pe();
    cmp("end2_done", int'({done, W_valid}), 2);

    // one-shot
    wr(0, 100); wr(1, 200); wr(2, 300);
    go(3, 1'b0);
    cmp("os_first", int'(W), 100);
    repeat (3) step();
    cmp("os_hold", int'(W), 100);
    pe(); cmp("os_2", int'(W), 200);
    pe(); cmp("os_3", int'(W), 300);
    pe(); cmp("os_end", int'({done, W_valid, busy}), 4);
    cmp("os_endW", int'(W), 0);

    // looping, then stop mid-period
    go(3, 1'b1);
    for (int k = 0; k < 5; k++) begin
      pe();
      cmp("loop_W", int'(W), exp_loop[k]);
      cmp("loop_busy", int'(busy), 1);
    end
    stop = 1'b1; step(); stop = 1'b0;
    step(); step();
    cmp("stop_hold", int'(W), 300);
    pe();
    cmp("stop_end", int'({done, W_valid, busy}), 4);

    // stop coincident with period_end
    go(3, 1'b1);
    pe();
    stop = 1'b1; period_end = 1'b1; step(); stop = 1'b0; period_end = 1'b0;
    cmp("stop_coinc", int'({done, W_valid}), 2);

    // guards
    go(0, 1'b0);
    cmp("len0", int'(busy), 0);
    go(9, 1'b0);
    cmp("len9", int'(busy), 0);
    go(3, 1'b1);
    wr(1, 5555);
    cmp("run_rej", int'(wr_rej), 1);
    pe();
    cmp("run_tab", int'(W), 200);
    en = 1'b0; period_end = 1'b1; step(); period_end = 1'b0; en = 1'b1;
    cmp("freeze_W", int'(W), 200);
    cmp("freeze_idx", int'(idx), 1);
    pe();
    cmp("idx2", int'(idx), 2);

    // async reset mid-RUN
    #2 reset = 1'b0;
    #1;
    cmp("arst", int'({W_valid, busy}), 0);
    cmp("arst_W_idx", int'(W) + int'(idx), 0);
    #1 reset = 1'b1;
    step();
    go(3, 1'b0);
    cmp("cleared", int'(W), 0);
    stop = 1'b1; period_end = 1'b1; step(); stop = 1'b0; period_end = 1'b0;

    // start with coincident write to entry 0
    wr(0, 111);
    wr_en = 1'b1; wr_addr = '0; wr_data = WW'(222);
    seq_len = (AW+1)'(1); loop = 1'b1; start = 1'b1;
    step();
    wr_en = 1'b0; start = 1'b0;
    cmp("prewrite", int'(W), 111);
    pe();
    cmp("postwrite", int'(W), 222);
    stop = 1'b1; period_end = 1'b1; step(); stop = 1'b0; period_end = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
